// File: rtl/sram_chip_model_sword.sv
// sram_chip_model_sword
// On-chip stand-in for the 48-bit asynchronous board SRAM on the SWORD pin bus.
// The SRAM controller talks to it exactly as it would to the physical part:
// reads are combinational from the address pins, writes commit on the clock
// edge. After reset an optional sweep fills every word with INIT_VALUE before
// accesses are serviced. Protocol misuse raises sticky error flags, and
// saturating counters record serviced reads and committed writes.

module sram_chip_model_sword #(
   parameter int unsigned ADDR_BITS  = 22,
   parameter int unsigned DEPTH_BITS = 12,
   parameter bit          INIT_CLEAR = 1'b1,
   parameter logic [47:0] INIT_VALUE = 48'h0,
   parameter int unsigned COUNT_BITS = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce_n,
   input  logic                  oe_n,
   input  logic                  we_n,
   input  logic [ADDR_BITS-1:2]  addr,
   input  logic [47:0]           data_in,
   output logic [47:0]           data_out,
   output logic                  ready,
   output logic                  err_contention,
   output logic                  err_range,
   output logic                  err_notready,
   output logic [COUNT_BITS-1:0] rd_count,
   output logic [COUNT_BITS-1:0] wr_count
);

   localparam int unsigned WORDS = 1 << DEPTH_BITS;

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Saturating increment: an all-ones counter holds its value.
   function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] value);
      logic [COUNT_BITS-1:0] result;
      if (value == {COUNT_BITS{1'b1}}) begin
         result = value;
      end else begin
         result = value + COUNT_BITS'(1);
      end
      return result;
   endfunction

   state_t                  state_r;
   logic [DEPTH_BITS-1:0]   ptr_r;
   logic                    ready_r;
   logic                    err_contention_r;
   logic                    err_range_r;
   logic                    err_notready_r;
   logic [COUNT_BITS-1:0]   rd_count_r;
   logic [COUNT_BITS-1:0]   wr_count_r;

   // Backing array; contents are deliberately not reset.
   logic [47:0]             mem_r [WORDS];

   logic                    in_range_s;
   logic [DEPTH_BITS-1:0]   word_idx_s;
   logic                    sel_s;
   logic                    contention_s;
   logic                    rd_ok_s;
   logic                    wr_ok_s;
   logic                    mem_we_s;
   logic [DEPTH_BITS-1:0]   mem_waddr_s;
   logic [47:0]             mem_wdata_s;
   logic [47:0]             rd_data_s;

   // Address bits above the implemented depth must be zero for an access to land.
   generate
      if (ADDR_BITS > DEPTH_BITS + 2) begin : g_range_check
         assign in_range_s = (addr[ADDR_BITS-1:DEPTH_BITS+2] == {(ADDR_BITS-DEPTH_BITS-2){1'b0}});
      end else begin : g_full_decode
         assign in_range_s = 1'b1;
      end
   endgenerate

   assign word_idx_s = addr[DEPTH_BITS+1:2];

   // Decode the pin state into the access classes that drive data, counters and flags.
   always_comb begin
      sel_s        = ~ce_n;
      contention_s = sel_s & ~oe_n & ~we_n;
      rd_ok_s      = ready_r & sel_s & ~oe_n &  we_n & in_range_s;
      wr_ok_s      = ready_r & sel_s & ~we_n &  oe_n & in_range_s;
   end

   // Single write port shared by the clear sweep and controller writes; they never overlap
   // because controller writes need ready, which is only set once the sweep is done.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = {DEPTH_BITS{1'b0}};
      mem_wdata_s = 48'h0;
      if ((state_r == S_INIT) && !rst) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = ptr_r;
         mem_wdata_s = INIT_VALUE;
      end else if (wr_ok_s) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = word_idx_s;
         mem_wdata_s = data_in;
      end else begin
         mem_we_s    = 1'b0;
      end
   end

   // Array write; a read of the same word shows the old data until this edge.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[mem_waddr_s] <= mem_wdata_s;
      end
   end

   // Zero-latency read path: the controller samples data on the edge after it drives addr.
   always_comb begin
      rd_data_s = 48'h0;
      if (rd_ok_s) begin
         rd_data_s = mem_r[word_idx_s];
      end else begin
         rd_data_s = 48'h0;
      end
   end

   // Sweep FSM; ready follows one cycle after the last word is cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= INIT_CLEAR ? S_INIT : S_RUN;
         ptr_r   <= {DEPTH_BITS{1'b0}};
         ready_r <= !INIT_CLEAR;
      end else begin
         case (state_r)
            S_INIT: begin
               ptr_r   <= ptr_r + DEPTH_BITS'(1);
               ready_r <= 1'b0;
               if (ptr_r == {DEPTH_BITS{1'b1}}) begin
                  state_r <= S_RUN;
               end else begin
                  state_r <= S_INIT;
               end
            end
            S_RUN: begin
               ready_r <= 1'b1;
               state_r <= S_RUN;
            end
            default: begin
               state_r <= S_INIT;
               ptr_r   <= {DEPTH_BITS{1'b0}};
               ready_r <= 1'b0;
            end
         endcase
      end
   end

   // Sticky protocol-error flags; only reset clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_contention_r <= 1'b0;
         err_range_r      <= 1'b0;
         err_notready_r   <= 1'b0;
      end else begin
         if (contention_s) begin
            err_contention_r <= 1'b1;
         end
         if (sel_s && !in_range_s) begin
            err_range_r <= 1'b1;
         end
         if (sel_s && !ready_r) begin
            err_notready_r <= 1'b1;
         end
      end
   end

   // Saturating read counter: one count per serviced read edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count_r <= {COUNT_BITS{1'b0}};
      end else if (rd_ok_s) begin
         rd_count_r <= sat_inc(rd_count_r);
      end
   end

   // Saturating write counter: one count per committed write edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count_r <= {COUNT_BITS{1'b0}};
      end else if (wr_ok_s) begin
         wr_count_r <= sat_inc(wr_count_r);
      end
   end

   assign data_out       = rd_data_s;
   assign ready          = ready_r;
   assign err_contention = err_contention_r;
   assign err_range      = err_range_r;
   assign err_notready   = err_notready_r;
   assign rd_count       = rd_count_r;
   assign wr_count       = wr_count_r;

endmodule

// File: tb/tb_sram_chip_model_sword.sv
// Bench for sram_chip_model_sword: directed scenarios plus a randomized phase,
// all checked against a behavioural model of the SRAM stand-in.

module tb_sram_chip_model_sword;

   localparam int          AB    = 22;
   localparam int          DB    = 4;
   localparam int          CB    = 6;
   localparam logic [47:0] IV    = 48'h5A5A;
   localparam int          NW    = 1 << DB;
   localparam int          CMAX  = (1 << CB) - 1;
   localparam int          RDYAT = NW + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          ce_n;
   logic          oe_n;
   logic          we_n;
   logic [AB-1:2] addr;
   logic [47:0]   data_in;
   logic [47:0]   data_out;
   logic          ready;
   logic          err_contention;
   logic          err_range;
   logic          err_notready;
   logic [CB-1:0] rd_count;
   logic [CB-1:0] wr_count;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // behavioural model state
   logic [47:0] m_mem [NW];
   int          m_edges;
   bit          m_ready;
   bit          m_cont;
   bit          m_range;
   bit          m_nr;
   int          m_rd;
   int          m_wr;

   logic [47:0] burst_w [4];

   sram_chip_model_sword #(
      .ADDR_BITS (AB),
      .DEPTH_BITS(DB),
      .INIT_CLEAR(1'b1),
      .INIT_VALUE(IV),
      .COUNT_BITS(CB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ce_n          (ce_n),
      .oe_n          (oe_n),
      .we_n          (we_n),
      .addr          (addr),
      .data_in       (data_in),
      .data_out      (data_out),
      .ready         (ready),
      .err_contention(err_contention),
      .err_range     (err_range),
      .err_notready  (err_notready),
      .rd_count      (rd_count),
      .wr_count      (wr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [47:0] rnd48();
      return {16'($urandom), 32'($urandom)};
   endfunction

   function automatic bit in_rng(input logic [AB-1:2] a);
      return (a[AB-1:DB+2] == '0);
   endfunction

   // expected combinational read value for the current pins
   function automatic logic [47:0] exp_read();
      if (m_ready && !ce_n && !oe_n && we_n && in_rng(addr)) return m_mem[addr[DB+1:2]];
      return 48'h0;
   endfunction

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_edges = 0;
      m_ready = 1'b0;
      m_cont  = 1'b0;
      m_range = 1'b0;
      m_nr    = 1'b0;
      m_rd    = 0;
      m_wr    = 0;
   endtask

   // one clock edge of the model, using the pins applied before it
   task automatic model_edge();
      bit sel;
      bit inr;
      sel = !ce_n;
      inr = in_rng(addr);
      if (sel && !oe_n && !we_n) m_cont = 1'b1;
      if (sel && !inr) m_range = 1'b1;
      if (sel && !m_ready) m_nr = 1'b1;
      if (m_ready && sel && inr && !we_n && oe_n) begin
         m_mem[addr[DB+1:2]] = data_in;
         if (m_wr < CMAX) m_wr++;
      end
      if (m_ready && sel && inr && !oe_n && we_n) begin
         if (m_rd < CMAX) m_rd++;
      end
      m_edges++;
      if (!m_ready && m_edges == RDYAT) begin
         m_ready = 1'b1;
         for (int i = 0; i < NW; i++) m_mem[i] = IV;
      end
   endtask

   // apply pins, check the read path, clock once, check registered outputs
   task automatic step(input bit c, input bit o, input bit w,
                       input logic [AB-1:2] a, input logic [47:0] d);
      ce_n = c; oe_n = o; we_n = w; addr = a; data_in = d;
      #2;
      chk("data_out", data_out, exp_read());
      @(posedge clk);
      model_edge();
      #1;
      chk("ready",          {47'h0, ready},          {47'h0, m_ready});
      chk("err_contention", {47'h0, err_contention}, {47'h0, m_cont});
      chk("err_range",      {47'h0, err_range},      {47'h0, m_range});
      chk("err_notready",   {47'h0, err_notready},   {47'h0, m_nr});
      chk("rd_count",       48'(rd_count),           48'(m_rd));
      chk("wr_count",       48'(wr_count),           48'(m_wr));
   endtask

   task automatic idle();
      step(1'b1, 1'b1, 1'b1, 20'h0, 48'h0);
   endtask

   // async reset pulse held across one edge, released just after an edge
   task automatic do_reset();
      rst = 1'b1;
      ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
      #1;
      model_reset();
      chk("rst_ready",   {47'h0, ready},        48'h0);
      chk("rst_errs",    {45'h0, err_contention, err_range, err_notready}, 48'h0);
      chk("rst_rdcount", 48'(rd_count),         48'h0);
      chk("rst_wrcount", 48'(wr_count),         48'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // sweep after reset: ready must rise on exactly the 17th edge
   task automatic sweep_wait();
      for (int i = 1; i <= RDYAT; i++) begin
         idle();
         chk("ready_rise", {47'h0, ready}, {47'h0, (i == RDYAT)});
      end
   endtask

   initial begin
      rst = 1'b1; ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
      addr = '0; data_in = '0;
      @(posedge clk);
      #1;
      do_reset();
      sweep_wait();

      // single write then reads of the same word
      step(1'b0, 1'b1, 1'b0, 20'h3, 48'h123456789ABC);
      chk("t2_wr", 48'(wr_count), 48'd1);
      step(1'b0, 1'b0, 1'b1, 20'h3, 48'h0);
      chk("t2_data", data_out, 48'h123456789ABC);
      chk("t2_rd1", 48'(rd_count), 48'd1);
      step(1'b0, 1'b0, 1'b1, 20'h3, 48'h0);
      chk("t2_rd2", 48'(rd_count), 48'd2);

      // every other word still holds the sweep value
      for (int i = 0; i < NW; i++) begin
         if (i != 3) begin
            step(1'b0, 1'b0, 1'b1, 20'(i), 48'h0);
            chk("sweep_word", data_out, IV);
         end
      end

      // contention on addr 5 holding 1
      step(1'b0, 1'b1, 1'b0, 20'h5, 48'h1);
      step(1'b0, 1'b0, 1'b0, 20'h5, 48'hFFFF_FFFF_FFFF);
      chk("t4_flag", {47'h0, err_contention}, 48'h1);
      step(1'b0, 1'b0, 1'b1, 20'h5, 48'h0);
      chk("t4_keep", data_out, 48'h1);

      // out-of-range write aliasing word 0
      step(1'b0, 1'b1, 1'b0, 20'h00010, 48'hDEAD_BEEF_0001);
      chk("t5_flag", {47'h0, err_range}, 48'h1);
      step(1'b0, 1'b0, 1'b1, 20'h0, 48'h0);
      chk("t5_word0", data_out, IV);

      // controller-style burst write then 2-cycle reads of 8..11
      for (int i = 0; i < 4; i++) burst_w[i] = rnd48();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 20'(8 + i), burst_w[i]);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1, 20'(8 + i), 48'h0);
         step(1'b0, 1'b0, 1'b1, 20'(8 + i), 48'h0);
         chk("t3_burst", data_out, burst_w[i]);
      end

      // randomized traffic
      for (int n = 0; n < 200; n++) begin
         logic [AB-1:2] a;
         if ($urandom_range(0, 9) == 0) a = 20'($urandom);
         else a = 20'($urandom_range(0, NW - 1));
         step(1'($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom), a, rnd48());
      end

      // counters saturate and stay there
      for (int n = 0; n < CMAX + 8; n++) step(1'b0, 1'b0, 1'b1, 20'h0, 48'h0);
      for (int n = 0; n < CMAX + 8; n++) step(1'b0, 1'b1, 1'b0, 20'h1, rnd48());
      chk("sat_rd", 48'(rd_count), 48'(CMAX));
      chk("sat_wr", 48'(wr_count), 48'(CMAX));

      // access during sweep, then reset mid-sweep restarts it
      do_reset();
      for (int i = 0; i < 4; i++) idle();
      step(1'b0, 1'b1, 1'b0, 20'h3, rnd48());
      chk("t6_notready", {47'h0, err_notready}, 48'h1);
      chk("t6_nowrite", 48'(wr_count), 48'h0);
      for (int i = 0; i < 3; i++) idle();
      do_reset();
      chk("t6_cleared", {47'h0, err_notready}, 48'h0);
      sweep_wait();
      for (int i = 0; i < NW; i++) begin
         step(1'b0, 1'b0, 1'b1, 20'(i), 48'h0);
         chk("resweep_word", data_out, IV);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
